// File: rtl/operand_entry_if.sv
// Keypad-to-calculator bus: keypad strobes in, entered operands and ALU launch out.
// Handshake: read_input / operator_input!=0 / equal_input act as valid; key_read is the
// one-cycle acknowledge one cycle after acceptance, and the source must present an
// all-idle cycle before the next key is accepted.
interface operand_entry_if;
  logic        read_input;
  logic [3:0]  keypad_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        key_read;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [2:0]  alu_op;
  logic        calc_start;
  logic [15:0] display_value;
  logic        overflow_flag;
  logic [1:0]  entry_state;

  modport slave (
    input  read_input, keypad_input, operator_input, equal_input,
    output key_read, operand_a, operand_b, alu_op, calc_start,
           display_value, overflow_flag, entry_state
  );

  modport master (
    output read_input, keypad_input, operator_input, equal_input,
    input  key_read, operand_a, operand_b, alu_op, calc_start,
           display_value, overflow_flag, entry_state
  );
endinterface

// File: rtl/operand_entry.sv
// Calculator operand entry: assembles signed decimal operands from keypad events,
// latches the operator and launches the ALU on equals.
module operand_entry (
  input  logic            clk,
  input  logic            nRST,
  operand_entry_if.slave  kp
);

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    DONE    = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        armed_q, armed_d;
  logic        hold_q, hold_d;
  logic        key_read_q, key_read_d;
  logic        calc_start_q, calc_start_d;
  logic [15:0] operand_a_q, operand_a_d;
  logic [15:0] operand_b_q, operand_b_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [15:0] display_q, display_d;
  logic        overflow_q, overflow_d;
  logic [16:0] mag_q, mag_d;
  logic        neg_q, neg_d;
  logic        has_digit_q, has_digit_d;

  logic        any_key, evt, is_eq, is_op, is_dig, is_minus, is_arith;
  logic [16:0] base_mag;
  logic        base_neg;
  logic [19:0] prod, limit;

  function automatic logic [15:0] apply_sign(input logic neg, input logic [15:0] mag);
    apply_sign = neg ? (~mag + 16'd1) : mag;
  endfunction

  always_comb begin
    any_key  = kp.read_input | (kp.operator_input != 3'b000) | kp.equal_input;
    // hold_q keeps keys held across reset release from being taken until an idle cycle
    evt      = armed_q & ~hold_q & any_key;
    is_eq    = kp.equal_input;
    is_op    = ~kp.equal_input & (kp.operator_input != 3'b000);
    is_dig   = ~kp.equal_input & (kp.operator_input == 3'b000) & kp.read_input;
    is_minus = is_op & (kp.operator_input == 3'b001);
    is_arith = is_op & (kp.operator_input inside {3'b010, 3'b011, 3'b100});

    // A key typed in DONE starts a fresh operand A, so it builds on an empty magnitude
    base_mag = (state_q == DONE) ? 17'd0 : mag_q;
    base_neg = (state_q == DONE) ? 1'b0 : neg_q;
    prod     = {3'b000, base_mag} * 20'd10 + {16'd0, kp.keypad_input};
    limit    = base_neg ? 20'd32768 : 20'd32767;

    state_d      = state_q;
    armed_d      = armed_q ? ~evt : ~any_key;
    hold_d       = hold_q & any_key;
    key_read_d   = evt;
    calc_start_d = 1'b0;
    operand_a_d  = operand_a_q;
    operand_b_d  = operand_b_q;
    alu_op_d     = alu_op_q;
    overflow_d   = overflow_q;
    mag_d        = mag_q;
    neg_d        = neg_q;
    has_digit_d  = has_digit_q;

    if (state_q == ILLEGAL) begin
      state_d = ENTRY_A;
    end else if (evt) begin
      if (is_eq) begin
        if (state_q == ENTRY_B && has_digit_q) begin
          operand_b_d  = apply_sign(neg_q, mag_q[15:0]);
          calc_start_d = 1'b1;
          state_d      = DONE;
        end
      end else if (is_arith) begin
        if (state_q == ENTRY_A && has_digit_q) begin
          alu_op_d    = kp.operator_input;
          operand_a_d = apply_sign(neg_q, mag_q[15:0]);
          mag_d       = 17'd0;
          neg_d       = 1'b0;
          has_digit_d = 1'b0;
          overflow_d  = 1'b0;
          state_d     = ENTRY_B;
        end
      end else if (is_minus || is_dig) begin
        if (state_q == DONE) begin
          operand_a_d = 16'd0;
          operand_b_d = 16'd0;
          alu_op_d    = 3'b000;
          overflow_d  = 1'b0;
          mag_d       = 17'd0;
          neg_d       = 1'b0;
          has_digit_d = 1'b0;
          state_d     = ENTRY_A;
        end
        if (is_minus) begin
          if (state_q == DONE || !has_digit_q) neg_d = 1'b1;
        end else if (prod <= limit) begin
          mag_d       = prod[16:0];
          has_digit_d = 1'b1;
        end else begin
          overflow_d  = 1'b1;
        end
      end
    end

    display_d = (state_d == DONE) ? operand_b_d : apply_sign(neg_d, mag_d[15:0]);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ENTRY_A;
      armed_q      <= 1'b1;
      hold_q       <= 1'b1;
      key_read_q   <= 1'b0;
      calc_start_q <= 1'b0;
      operand_a_q  <= 16'd0;
      operand_b_q  <= 16'd0;
      alu_op_q     <= 3'b000;
      display_q    <= 16'd0;
      overflow_q   <= 1'b0;
      mag_q        <= 17'd0;
      neg_q        <= 1'b0;
      has_digit_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      hold_q       <= hold_d;
      key_read_q   <= key_read_d;
      calc_start_q <= calc_start_d;
      operand_a_q  <= operand_a_d;
      operand_b_q  <= operand_b_d;
      alu_op_q     <= alu_op_d;
      display_q    <= display_d;
      overflow_q   <= overflow_d;
      mag_q        <= mag_d;
      neg_q        <= neg_d;
      has_digit_q  <= has_digit_d;
    end
  end

  assign kp.key_read      = key_read_q;
  assign kp.calc_start    = calc_start_q;
  assign kp.operand_a     = operand_a_q;
  assign kp.operand_b     = operand_b_q;
  assign kp.alu_op        = alu_op_q;
  assign kp.display_value = display_q;
  assign kp.overflow_flag = overflow_q;
  assign kp.entry_state   = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed scenarios plus random key streams checked
// against an integer-arithmetic calculator model.
module tb_operand_entry;

  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  operand_entry_if bus ();
  operand_entry dut (.clk(clk), .nRST(nRST), .kp(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference calculator: phase 0 = entering A, 1 = entering B, 2 = result shown
  int m_phase, m_mag, m_digits, m_a, m_b, m_op;
  bit m_neg, m_ovf;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] to16(input int v);
    logic [31:0] t;
    t = v;
    return t[15:0];
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_mag = 0; m_digits = 0; m_a = 0; m_b = 0; m_op = 0;
    m_neg = 1'b0; m_ovf = 1'b0;
  endfunction

  function automatic void model_new_entry();
    m_a = 0; m_b = 0; m_op = 0; m_ovf = 1'b0;
    m_mag = 0; m_neg = 1'b0; m_digits = 0; m_phase = 0;
  endfunction

  function automatic int model_value();
    return m_neg ? -m_mag : m_mag;
  endfunction

  function automatic logic [15:0] model_display();
    return (m_phase == 2) ? to16(m_b) : to16(model_value());
  endfunction

  // Applies one accepted key event; returns whether calc_start must pulse
  function automatic bit model_key(input bit rd, input int dig, input int op, input bit eq);
    int cand;
    bit cs;
    cs = 1'b0;
    if (eq) begin
      if (m_phase == 1 && m_digits > 0) begin
        m_b = model_value(); m_phase = 2; cs = 1'b1;
      end
    end else if (op != 0) begin
      if (op == 1) begin
        if (m_phase == 2) begin model_new_entry(); m_neg = 1'b1; end
        else if (m_digits == 0) m_neg = 1'b1;
      end else if (op >= 2 && op <= 4 && m_phase == 0 && m_digits > 0) begin
        m_a = model_value(); m_op = op;
        m_mag = 0; m_neg = 1'b0; m_digits = 0; m_ovf = 1'b0; m_phase = 1;
      end
    end else if (rd) begin
      if (m_phase == 2) model_new_entry();
      cand = m_mag * 10 + dig;
      if (cand <= (m_neg ? 32768 : 32767)) begin m_mag = cand; m_digits++; end
      else m_ovf = 1'b1;
    end
    return cs;
  endfunction

  task automatic drive_idle();
    bus.read_input = 1'b0; bus.keypad_input = 4'd0;
    bus.operator_input = 3'd0; bus.equal_input = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    nRST = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // One key stroke: hold for one cycle then idle; samples the ack cycle and the one after
  task automatic press(input bit rd, input logic [3:0] dig, input logic [2:0] op, input bit eq,
                       output bit kr1, output bit cs1, output bit kr2, output bit cs2,
                       output bit exp_cs);
    @(negedge clk);
    bus.read_input = rd; bus.keypad_input = dig;
    bus.operator_input = op; bus.equal_input = eq;
    exp_cs = model_key(rd, int'(dig), int'(op), eq);
    @(negedge clk);
    kr1 = bus.key_read; cs1 = bus.calc_start;
    drive_idle();
    @(negedge clk);
    kr2 = bus.key_read; cs2 = bus.calc_start;
  endtask

  task automatic test_reset();
    drive_idle();
    nRST = 1'b0;
    #1;
    n_vec++; if (bus.key_read !== 1'b0) begin n_err++; $display("FAIL rst_key_read got %b exp 0", bus.key_read); end
    n_vec++; if (bus.calc_start !== 1'b0) begin n_err++; $display("FAIL rst_calc_start got %b exp 0", bus.calc_start); end
    n_vec++; if (bus.operand_a !== 16'd0 || bus.operand_b !== 16'd0) begin n_err++; $display("FAIL rst_operands got %h/%h exp 0000/0000", bus.operand_a, bus.operand_b); end
    n_vec++; if (bus.alu_op !== 3'd0) begin n_err++; $display("FAIL rst_alu_op got %b exp 000", bus.alu_op); end
    n_vec++; if (bus.display_value !== 16'd0 || bus.overflow_flag !== 1'b0) begin n_err++; $display("FAIL rst_display got %h ovf %b exp 0000 0", bus.display_value, bus.overflow_flag); end
    n_vec++; if (bus.entry_state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d exp 0", bus.entry_state); end
    @(negedge clk);
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_basic();
    bit kr1, cs1, kr2, cs2, ecs;
    int acks, pulses;
    logic [2:0] ops [7];
    logic [3:0] digs[7];
    bit         eqs [7];
    ops  = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
    digs = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd4, 4'd5, 4'd0};
    eqs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    acks = 0; pulses = 0;
    for (int i = 0; i < 7; i++) begin
      press(ops[i] == 3'd0 && !eqs[i], digs[i], ops[i], eqs[i], kr1, cs1, kr2, cs2, ecs);
      acks += int'(kr1) + int'(kr2);
      pulses += int'(cs1) + int'(cs2);
    end
    n_vec++; if (acks != 7) begin n_err++; $display("FAIL basic_acks got %0d exp 7", acks); end
    n_vec++; if (pulses != 1 || cs1 !== 1'b1) begin n_err++; $display("FAIL basic_calc_start pulses %0d last %b exp 1 1", pulses, cs1); end
    n_vec++; if (bus.operand_a !== 16'd123 || bus.operand_b !== 16'd45) begin n_err++; $display("FAIL basic_operands got %0d/%0d exp 123/45", bus.operand_a, bus.operand_b); end
    n_vec++; if (bus.alu_op !== 3'b010 || bus.entry_state !== 2'd2) begin n_err++; $display("FAIL basic_op_state got %b/%0d exp 010/2", bus.alu_op, bus.entry_state); end
    n_vec++; if (bus.display_value !== 16'd45) begin n_err++; $display("FAIL basic_display got %0d exp 45", bus.display_value); end
  endtask

  task automatic test_negative();
    bit kr1, cs1, kr2, cs2, ecs;
    logic [3:0] digs[5];
    digs = '{4'd3, 4'd2, 4'd7, 4'd6, 4'd8};
    press(1'b0, 4'd0, 3'd1, 1'b0, kr1, cs1, kr2, cs2, ecs);
    n_vec++; if (bus.entry_state !== 2'd0 || bus.operand_a !== 16'd0 || bus.alu_op !== 3'd0) begin n_err++; $display("FAIL neg_restart state %0d a %h op %b exp 0 0000 000", bus.entry_state, bus.operand_a, bus.alu_op); end
    for (int i = 0; i < 5; i++) press(1'b1, digs[i], 3'd0, 1'b0, kr1, cs1, kr2, cs2, ecs);
    n_vec++; if (bus.display_value !== 16'h8000) begin n_err++; $display("FAIL neg_display got %h exp 8000", bus.display_value); end
    press(1'b0, 4'd0, 3'd3, 1'b0, kr1, cs1, kr2, cs2, ecs);
    press(1'b1, 4'd1, 3'd0, 1'b0, kr1, cs1, kr2, cs2, ecs);
    press(1'b0, 4'd0, 3'd0, 1'b1, kr1, cs1, kr2, cs2, ecs);
    n_vec++; if (bus.operand_a !== 16'h8000 || bus.operand_b !== 16'd1) begin n_err++; $display("FAIL neg_operands got %h/%h exp 8000/0001", bus.operand_a, bus.operand_b); end
    n_vec++; if (bus.overflow_flag !== 1'b0 || bus.alu_op !== 3'b011 || cs1 !== 1'b1) begin n_err++; $display("FAIL neg_flags ovf %b op %b cs %b exp 0 011 1", bus.overflow_flag, bus.alu_op, cs1); end
  endtask

  task automatic test_overflow();
    bit kr1, cs1, kr2, cs2, ecs;
    int acks;
    logic [3:0] digs[5];
    digs = '{4'd3, 4'd2, 4'd7, 4'd6, 4'd8};
    do_reset();
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      press(1'b1, digs[i], 3'd0, 1'b0, kr1, cs1, kr2, cs2, ecs);
      acks += int'(kr1) + int'(kr2);
    end
    n_vec++; if (bus.display_value !== 16'd3276) begin n_err++; $display("FAIL ovf_display got %0d exp 3276", bus.display_value); end
    n_vec++; if (bus.overflow_flag !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", bus.overflow_flag); end
    n_vec++; if (acks != 5) begin n_err++; $display("FAIL ovf_acks got %0d exp 5", acks); end
  endtask

  task automatic test_hold();
    bit kr1, cs1, kr2, cs2, ecs;
    int acks;
    do_reset();
    acks = 0;
    @(negedge clk);
    bus.read_input = 1'b1; bus.keypad_input = 4'd7;
    ecs = model_key(1'b1, 7, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acks += int'(bus.key_read);
    end
    drive_idle();
    @(negedge clk);
    acks += int'(bus.key_read);
    n_vec++; if (acks != 1) begin n_err++; $display("FAIL hold_acks got %0d exp 1", acks); end
    n_vec++; if (bus.display_value !== 16'd7) begin n_err++; $display("FAIL hold_display got %0d exp 7", bus.display_value); end
    press(1'b1, 4'd2, 3'd0, 1'b0, kr1, cs1, kr2, cs2, ecs);
    n_vec++; if (kr1 !== 1'b1 || bus.display_value !== 16'd72) begin n_err++; $display("FAIL hold_rearm ack %b display %0d exp 1 72", kr1, bus.display_value); end
  endtask

  task automatic test_ignored();
    bit kr1, cs1, kr2, cs2, ecs;
    do_reset();
    press(1'b0, 4'd0, 3'd2, 1'b0, kr1, cs1, kr2, cs2, ecs);
    n_vec++; if (kr1 !== 1'b1 || bus.entry_state !== 2'd0 || bus.alu_op !== 3'd0) begin n_err++; $display("FAIL ign_op ack %b state %0d op %b exp 1 0 000", kr1, bus.entry_state, bus.alu_op); end
    press(1'b0, 4'd0, 3'd0, 1'b1, kr1, cs1, kr2, cs2, ecs);
    n_vec++; if (kr1 !== 1'b1 || cs1 !== 1'b0 || cs2 !== 1'b0 || bus.entry_state !== 2'd0) begin n_err++; $display("FAIL ign_eq ack %b cs %b%b state %0d exp 1 00 0", kr1, cs1, cs2, bus.entry_state); end
  endtask

  task automatic test_reset_mid();
    bit kr1, cs1, kr2, cs2, ecs;
    int acks;
    do_reset();
    press(1'b1, 4'd1, 3'd0, 1'b0, kr1, cs1, kr2, cs2, ecs);
    press(1'b0, 4'd0, 3'd2, 1'b0, kr1, cs1, kr2, cs2, ecs);
    press(1'b1, 4'd5, 3'd0, 1'b0, kr1, cs1, kr2, cs2, ecs);
    @(negedge clk);
    bus.equal_input = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (bus.key_read !== 1'b1 || bus.calc_start !== 1'b1) begin n_err++; $display("FAIL mid_pending ack %b cs %b exp 1 1", bus.key_read, bus.calc_start); end
    nRST = 1'b0;
    #1;
    n_vec++; if (bus.key_read !== 1'b0 || bus.calc_start !== 1'b0 || bus.entry_state !== 2'd0) begin n_err++; $display("FAIL mid_drop ack %b cs %b state %0d exp 0 0 0", bus.key_read, bus.calc_start, bus.entry_state); end
    n_vec++; if (bus.operand_a !== 16'd0 || bus.operand_b !== 16'd0 || bus.display_value !== 16'd0 || bus.alu_op !== 3'd0) begin n_err++; $display("FAIL mid_clear a %h b %h d %h op %b exp zeros", bus.operand_a, bus.operand_b, bus.display_value, bus.alu_op); end
    model_reset();
    @(negedge clk);
    nRST = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acks += int'(bus.key_read) + int'(bus.calc_start);
    end
    n_vec++; if (acks != 0 || bus.entry_state !== 2'd0) begin n_err++; $display("FAIL mid_held strobes %0d state %0d exp 0 0", acks, bus.entry_state); end
    drive_idle();
    press(1'b1, 4'd4, 3'd0, 1'b0, kr1, cs1, kr2, cs2, ecs);
    n_vec++; if (kr1 !== 1'b1 || bus.display_value !== 16'd4) begin n_err++; $display("FAIL mid_after ack %b display %0d exp 1 4", kr1, bus.display_value); end
  endtask

  task automatic test_random();
    bit kr1, cs1, kr2, cs2, ecs, rd, eq;
    logic [3:0] dig;
    logic [2:0] op;
    logic [15:0] exp_disp;
    int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r   = int'($urandom_range(0, 99));
      dig = 4'($urandom_range(0, 9));
      rd = 1'b0; op = 3'd0; eq = 1'b0;
      if (r < 62) rd = 1'b1;
      else if (r < 72) op = 3'd1;
      else if (r < 82) op = 3'($urandom_range(2, 4));
      else if (r < 92) eq = 1'b1;
      else begin
        rd = 1'($urandom); op = 3'($urandom_range(0, 7)); eq = 1'($urandom);
        if (!rd && op == 3'd0 && !eq) op = 3'($urandom_range(5, 7));
      end
      press(rd, dig, op, eq, kr1, cs1, kr2, cs2, ecs);
      exp_q.push_back(model_display());
      exp_disp = exp_q.pop_front();
      n_vec++; if (kr1 !== 1'b1 || kr2 !== 1'b0) begin n_err++; $display("FAIL rnd_ack i=%0d got %b%b exp 10", i, kr1, kr2); end
      n_vec++; if (cs1 !== ecs || cs2 !== 1'b0) begin n_err++; $display("FAIL rnd_calc_start i=%0d got %b%b exp %b0", i, cs1, cs2, ecs); end
      n_vec++; if (bus.display_value !== exp_disp) begin n_err++; $display("FAIL rnd_display i=%0d got %h exp %h", i, bus.display_value, exp_disp); end
      n_vec++; if (bus.overflow_flag !== m_ovf || bus.entry_state !== 2'(m_phase)) begin n_err++; $display("FAIL rnd_flags i=%0d ovf %b state %0d exp %b %0d", i, bus.overflow_flag, bus.entry_state, m_ovf, m_phase); end
      n_vec++; if (bus.operand_a !== to16(m_a) || bus.operand_b !== to16(m_b) || bus.alu_op !== 3'(m_op)) begin n_err++; $display("FAIL rnd_operands i=%0d a %h b %h op %b exp %h %h %0d", i, bus.operand_a, bus.operand_b, bus.alu_op, to16(m_a), to16(m_b), m_op); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_hold();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
